command_scheduler: RTL and testbench

- Parametrised successor to the single-command processor.
- Buffers a host command stream in a FIFO and decodes variable-length commands (header plus 0..MAX_ARGS argument words).
- Dispatches each command to one of N_ENG engines (clear, raster, simd, ...) with start/done handshakes, letting different engines run concurrently.
- Adds fence ordering, per-engine watchdog timeouts and error reporting. Sits between the AXI-Lite/DMA command front end and the pixel engines.

---
 rtl/command_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_command_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/command_scheduler.sv
// Command scheduler: buffers host command words, decodes variable-length commands
// and dispatches them to concurrent engines with fence ordering and per-engine watchdogs.
module command_scheduler #(
  parameter int N_ENG      = 3,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_ARGS   = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  input  logic [DATA_W-1:0]            cmd_data,
  output logic                         cmd_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [N_ENG-1:0]             eng_start,
  input  logic [N_ENG-1:0]             eng_done,
  output logic [N_ENG-1:0]             eng_busy,
  output logic [DATA_W-1:0]            eng_hdr,
  output logic [MAX_ARGS*DATA_W-1:0]   eng_args,
  output logic                         err_valid,
  output logic [1:0]                   err_code
);

  // state | meaning
  // IDLE  | wait for a header word, pop and decode it
  // ARGS  | collect nargs argument words
  // DROP  | discard argument words of a rejected command
  // CHECK | wait for fence and target engine to be free
  // ISSUE | pulse start, publish header/args, mark engine busy
  typedef enum logic [2:0] {IDLE, ARGS, DROP, CHECK, ISSUE} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       level;
  logic              push, pop, empty;
  logic [DATA_W-1:0] head;

  state_t                     state, state_n;
  logic [DATA_W-1:0]          hdr_q;
  logic [MAX_ARGS*DATA_W-1:0] args_q;
  logic [3:0]                 cnt;
  logic [3:0]                 op_q, nargs_q;
  logic                       fence_q;
  logic [N_ENG-1:0]           op_oh;
  logic                       bad_op, bad_n, dec_err;
  logic [1:0]                 dec_code;
  logic [N_ENG-1:0]           tmo;
  logic [31:0]                wd [N_ENG];

  assign empty      = (level == '0);
  assign cmd_ready  = (level != LW'(FIFO_DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem[rd_ptr];
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign op_q    = hdr_q[31:28];
  assign nargs_q = hdr_q[27:24];
  assign fence_q = hdr_q[23];
  assign bad_op  = ({1'b0, head[31:28]} >= 5'(N_ENG));
  assign bad_n   = (head[27:24] > 4'(MAX_ARGS));

  always_comb begin
    op_oh = '0;
    for (int i = 0; i < N_ENG; i++) op_oh[i] = (op_q == 4'(i));
  end

  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    dec_err  = 1'b0;
    dec_code = 2'd0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (bad_op || bad_n) begin
            dec_err  = 1'b1;
            dec_code = bad_op ? 2'd1 : 2'd2;
            state_n  = DROP;
          end else if (head[27:24] == 4'd0) begin
            state_n = CHECK;
          end else begin
            state_n = ARGS;
          end
        end
      end
      ARGS: begin
        if (!empty) begin
          pop = 1'b1;
          if (cnt == nargs_q - 4'd1) state_n = CHECK;
        end
      end
      DROP: begin
        if (cnt == nargs_q) begin
          state_n = IDLE;
        end else if (!empty) begin
          pop = 1'b1;
          if (cnt == nargs_q - 4'd1) state_n = IDLE;
        end
      end
      CHECK: begin
        if (!(fence_q && (|eng_busy)) && !(|(eng_busy & op_oh))) state_n = ISSUE;
      end
      ISSUE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign eng_start = (state == ISSUE) ? op_oh : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hdr_q    <= '0;
      args_q   <= '0;
      cnt      <= '0;
      eng_hdr  <= '0;
      eng_args <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && !empty) begin
        hdr_q  <= head;
        args_q <= '0;
        cnt    <= '0;
      end
      if ((state == ARGS || state == DROP) && pop) cnt <= cnt + 4'd1;
      if (state == ARGS && pop) begin
        for (int k = 0; k < MAX_ARGS; k++)
          if (cnt == 4'(k)) args_q[k*DATA_W +: DATA_W] <= head;
      end
      // Published copy only moves on issue, so later decodes cannot disturb it.
      if (state == CHECK && state_n == ISSUE) begin
        eng_hdr  <= hdr_q;
        eng_args <= args_q;
      end
    end
  end

  for (genvar g = 0; g < N_ENG; g++) begin : g_wd
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           wd[g] <= '0;
      else if (eng_start[g] || tmo[g])      wd[g] <= '0;
      else if (eng_busy[g] && TIMEOUT != 0) wd[g] <= wd[g] + 32'd1;
    end
    assign tmo[g] = (TIMEOUT != 0) && eng_busy[g] && (wd[g] == 32'(TIMEOUT - 1));
  end

  // A start in the same cycle as done wins, so that done is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_busy  <= '0;
      err_valid <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      eng_busy  <= eng_start | (eng_busy & ~eng_done & ~tmo);
      err_valid <= dec_err || (|tmo);
      if (dec_err)   err_code <= dec_code;
      else if (|tmo) err_code <= 2'd3;
    end
  end

endmodule

// File: tb/tb_command_scheduler.sv
// Directed self-checking bench for command_scheduler: decode, dispatch, fence,
// error reporting, backpressure, watchdog and reset.
module tb_command_scheduler;
  localparam int N_ENG = 3, DATA_W = 32, FIFO_DEPTH = 8, MAX_ARGS = 4, TIMEOUT = 16;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       cmd_valid = 1'b0;
  logic [DATA_W-1:0]          cmd_data = '0;
  logic                       cmd_ready;
  logic [3:0]                 fifo_level;
  logic [N_ENG-1:0]           eng_start;
  logic [N_ENG-1:0]           eng_done = '0;
  logic [N_ENG-1:0]           eng_busy;
  logic [DATA_W-1:0]          eng_hdr;
  logic [MAX_ARGS*DATA_W-1:0] eng_args;
  logic                       err_valid;
  logic [1:0]                 err_code;

  int checks = 0;
  int errors = 0;

  command_scheduler #(.N_ENG(N_ENG), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
                      .MAX_ARGS(MAX_ARGS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .fifo_level(fifo_level), .eng_start(eng_start),
    .eng_done(eng_done), .eng_busy(eng_busy), .eng_hdr(eng_hdr), .eng_args(eng_args),
    .err_valid(err_valid), .err_code(err_code));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_data  = w;
    while (cmd_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("push_ready_bound", 128'(n < 100), 128'(1));
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int s0, s1, n, errs;

    // reset values
    tick(); tick();
    chk("rst_ready", 128'(cmd_ready), 128'(1));
    chk("rst_level", 128'(fifo_level), 128'(0));
    chk("rst_start", 128'(eng_start), 128'(0));
    chk("rst_busy", 128'(eng_busy), 128'(0));
    chk("rst_err", 128'({err_valid, err_code}), 128'(0));
    rst_n = 1'b1;
    tick();

    // single nargs=0 command, start 2 cycles after header pop
    push(32'h0000_0000);
    chk("t1_pre", 128'(eng_start), 128'(0));
    tick(); tick();
    chk("t1_start", 128'(eng_start), 128'(3'b001));
    chk("t1_busy_pre", 128'(eng_busy), 128'(0));
    tick();
    chk("t1_start_pulse", 128'(eng_start), 128'(0));
    chk("t1_busy", 128'(eng_busy), 128'(3'b001));
    eng_done = 3'b001; tick(); eng_done = '0;
    chk("t1_done", 128'(eng_busy), 128'(0));

    // args and concurrency
    push(32'h1200_0000); push(32'hAAAA_0001); push(32'hBBBB_0002); push(32'h2000_0000);
    chk("t2_check", 128'(eng_start), 128'(0));
    tick();
    chk("t2_start1", 128'(eng_start), 128'(3'b010));
    chk("t2_hdr", 128'(eng_hdr), 128'(32'h1200_0000));
    chk("t2_args", eng_args, {64'h0, 32'hBBBB_0002, 32'hAAAA_0001});
    tick(); tick(); tick();
    chk("t2_start2", 128'(eng_start), 128'(3'b100));
    chk("t2_concurrent", 128'(eng_busy), 128'(3'b010));
    chk("t2_args_zero", eng_args, 128'(0));
    tick();
    chk("t2_busy_both", 128'(eng_busy), 128'(3'b110));
    eng_done = 3'b110; tick(); eng_done = '0;
    chk("t2_done", 128'(eng_busy), 128'(0));

    // fence
    push(32'h0000_0000); tick(); tick(); tick();
    chk("t3_busy0", 128'(eng_busy), 128'(3'b001));
    push(32'h2080_0000);
    s0 = 0;
    repeat (5) begin
      tick();
      if (eng_start != '0) s0++;
    end
    chk("t3_fence_hold", 128'(s0), 128'(0));
    eng_done = 3'b001; tick(); eng_done = '0;
    chk("t3_cleared", 128'({eng_busy, eng_start}), 128'(0));
    tick();
    chk("t3_start2", 128'(eng_start), 128'(3'b100));
    tick();
    eng_done = 3'b100; tick(); eng_done = '0;

    // bad opcode, args dropped
    push(32'h7200_0000);
    chk("t4_err_pre", 128'(err_valid), 128'(0));
    push(32'h0000_0001);
    chk("t4_err_valid", 128'(err_valid), 128'(1));
    chk("t4_err_code", 128'(err_code), 128'(1));
    push(32'h0000_0002);
    chk("t4_err_pulse", 128'({err_valid, err_code}), 128'({1'b0, 2'd1}));
    push(32'h0000_0000);
    tick();
    chk("t4_no_early", 128'(eng_start), 128'(0));
    tick();
    chk("t4_start0", 128'(eng_start), 128'(3'b001));
    tick();
    eng_done = 3'b001; tick(); eng_done = '0;

    // bad nargs, five words dropped
    push(32'h0500_0000);
    push(32'h0000_0000);
    chk("t5_err", 128'({err_valid, err_code}), 128'({1'b1, 2'd2}));
    repeat (4) push(32'h0000_0000);
    push(32'h1000_0000);
    s0 = 0; s1 = 0;
    repeat (8) begin
      tick();
      if (eng_start[0]) s0++;
      if (eng_start[1]) s1++;
    end
    chk("t5_dropped", 128'(s0), 128'(0));
    chk("t5_marker", 128'(s1), 128'(1));
    eng_done = 3'b010; tick(); eng_done = '0;
    chk("t5_code_held", 128'({eng_busy, err_code}), 128'({3'b000, 2'd2}));

    // full FIFO / backpressure
    push(32'h0000_0000); tick(); tick(); tick();
    repeat (9) push(32'h0000_0000);
    chk("t6_level", 128'(fifo_level), 128'(8));
    chk("t6_ready", 128'(cmd_ready), 128'(0));
    s0 = 0; errs = 0; n = 0;
    while (!(s0 == 9 && eng_busy == '0) && n < 200) begin
      if (eng_start[0]) s0++;
      if (err_valid) errs++;
      eng_done = {2'b00, eng_busy[0]};
      tick();
      n++;
    end
    eng_done = '0;
    chk("t6_bound", 128'(n < 200), 128'(1));
    chk("t6_starts", 128'(s0), 128'(9));
    chk("t6_no_err", 128'(errs), 128'(0));
    chk("t6_drained", 128'({cmd_ready, fifo_level}), 128'({1'b1, 4'd0}));

    // watchdog
    push(32'h1000_0000); tick(); tick();
    chk("t7_start", 128'(eng_start), 128'(3'b010));
    tick();
    n = 0;
    while (eng_busy[1] && n < 40) begin
      n++;
      tick();
    end
    chk("t7_busy_cycles", 128'(n), 128'(16));
    chk("t7_err", 128'({err_valid, err_code}), 128'({1'b1, 2'd3}));
    tick();
    chk("t7_err_pulse", 128'(err_valid), 128'(0));
    eng_done = 3'b010; tick(); eng_done = '0;
    chk("t7_late_done", 128'({eng_busy, err_valid}), 128'(0));

    // reset mid-ARGS
    push(32'h1300_0000); push(32'h0000_AAAA); push(32'h0000_BBBB);
    rst_n = 1'b0;
    #1;
    chk("t8_rst_outs", 128'({cmd_ready, fifo_level, eng_start, eng_busy, err_valid, err_code}),
        128'({1'b1, 4'd0, 3'd0, 3'd0, 1'b0, 2'd0}));
    chk("t8_rst_hdr", 128'(eng_hdr), 128'(0));
    chk("t8_rst_args", eng_args, 128'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();
    push(32'h0000_0000); tick(); tick();
    chk("t8_clean_start", 128'(eng_start), 128'(3'b001));
    chk("t8_clean_args", eng_args, 128'(0));
    tick();
    eng_done = 3'b001; tick(); eng_done = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
